mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 38 +++
 rtl/mdu_sign_fix.sv | 11 +
 rtl/mdu.sv | 187 ++++++++++++++++++
 tb/tb_mdu.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op-bus bit positions, FSM encoding and operand helpers.
// Imported by the decode stage as well as by the MDU itself.
package mdu_pkg;

    localparam int MDU_VALID  = 0;
    localparam int MDU_WOP    = 1;
    localparam int MDU_MUL    = 2;
    localparam int MDU_MULH   = 3;
    localparam int MDU_MULHSU = 4;
    localparam int MDU_MULHU  = 5;
    localparam int MDU_DIV    = 6;
    localparam int MDU_DIVU   = 7;
    localparam int MDU_REM    = 8;
    localparam int MDU_REMU   = 9;
    localparam int MDU_BUS_W  = 10;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Word ops only look at the low half, widened according to the op's signedness.
    function automatic logic [63:0] ext_word(input logic [63:0] v, input logic wop, input logic sgn);
        if (!wop) begin
            return v;
        end else if (sgn) begin
            return {{32{v[31]}}, v[31:0]};
        end else begin
            return {32'd0, v[31:0]};
        end
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: magnitude extraction on the way in,
// sign restoration on the way out.
module mdu_sign_fix #(
    parameter int W = 64
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);
    assign result = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;
endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per cycle,
// sharing a 128-bit shift register and a 65-bit adder between both operations.
module mdu
    import mdu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic [MDU_BUS_W-1:0] mdu_info_bus_i,
    input  logic [63:0]          mdu_op1_i,
    input  logic [63:0]          mdu_op2_i,
    input  logic [4:0]           mdu_rd_idx_i,
    output logic                 mdu_ready_o,
    output logic                 mdu_busy_o,
    output logic                 mdu_res_valid_o,
    output logic [63:0]          mdu_res_o,
    output logic [4:0]           mdu_rd_idx_o,
    input  logic                 mdu_res_ready_i
);

    mdu_state_e   state_r;
    logic [6:0]   cnt_r;
    logic [127:0] acc_r;
    logic [63:0]  mcand_r, res_r;
    logic [4:0]   rd_r;
    logic         ready_r, busy_r, valid_r;
    logic         wop_r, is_div_r, rem_sel_r, high_r, neg_prod_r, neg_rem_r;

    logic [MDU_BUS_W-1:0] bus_s;
    logic         wop_s, sgn1_s, sgn2_s, is_div_s, neg1_s, neg2_s, div_zero_s, ovf_s;
    logic [63:0]  op1_ext_s, op2_ext_s, mag1_s, mag2_s, most_neg_s, dividend_s, special_res_s;
    logic [64:0]  add_a_s, add_b_s;
    logic [65:0]  sum_s;
    logic [127:0] acc_next_s, product_s, post_in_s, post_out_s;
    logic         post_neg_s;
    logic [63:0]  raw_s, final_s;

    assign bus_s    = mdu_info_bus_i;
    assign wop_s    = bus_s[MDU_WOP];
    assign sgn1_s   = bus_s[MDU_MUL] | bus_s[MDU_MULH] | bus_s[MDU_MULHSU] | bus_s[MDU_DIV] | bus_s[MDU_REM];
    assign sgn2_s   = bus_s[MDU_MUL] | bus_s[MDU_MULH] | bus_s[MDU_DIV] | bus_s[MDU_REM];
    assign is_div_s = bus_s[MDU_DIV] | bus_s[MDU_DIVU] | bus_s[MDU_REM] | bus_s[MDU_REMU];

    assign op1_ext_s = ext_word(mdu_op1_i, wop_s, sgn1_s);
    assign op2_ext_s = ext_word(mdu_op2_i, wop_s, sgn2_s);
    assign neg1_s    = sgn1_s & op1_ext_s[63];
    assign neg2_s    = sgn2_s & op2_ext_s[63];

    mdu_sign_fix #(.W(64)) u_pre1 (.value(op1_ext_s), .negate(neg1_s), .result(mag1_s));
    mdu_sign_fix #(.W(64)) u_pre2 (.value(op2_ext_s), .negate(neg2_s), .result(mag2_s));

    // Division special cases resolve at accept time and skip the iteration loop.
    assign most_neg_s = wop_s ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign div_zero_s = is_div_s && (op2_ext_s == 64'd0);
    assign ovf_s      = (bus_s[MDU_DIV] | bus_s[MDU_REM]) && (op1_ext_s == most_neg_s)
                        && (op2_ext_s == {64{1'b1}});
    assign dividend_s = ext_word(mdu_op1_i, wop_s, 1'b1);

    // Special-case result selection.
    always_comb begin
        special_res_s = 64'd0;
        if (bus_s[MDU_REM] | bus_s[MDU_REMU]) begin
            special_res_s = div_zero_s ? dividend_s : 64'd0;
        end else begin
            special_res_s = div_zero_s ? {64{1'b1}} : dividend_s;
        end
    end

    // Divide computes {rem, dividend_msb} - divisor; multiply computes hi + multiplicand.
    assign add_a_s = is_div_r ? acc_r[127:63] : {1'b0, acc_r[127:64]};
    assign add_b_s = is_div_r ? ~{1'b0, mcand_r} : {1'b0, mcand_r};
    assign sum_s   = {1'b0, add_a_s} + {1'b0, add_b_s} + {65'd0, is_div_r};

    // One iteration step; a carry out on subtract means no borrow.
    always_comb begin
        acc_next_s = acc_r;
        if (is_div_r) begin
            if (sum_s[65]) begin
                acc_next_s = {sum_s[63:0], acc_r[62:0], 1'b1};
            end else begin
                acc_next_s = {acc_r[126:0], 1'b0};
            end
        end else if (acc_r[0]) begin
            acc_next_s = {sum_s[64:0], acc_r[63:1]};
        end else begin
            acc_next_s = {1'b0, acc_r[127:1]};
        end
    end

    // After 32 multiply steps the word product sits 32 bits up in the accumulator.
    assign product_s  = wop_r ? {32'd0, acc_next_s[127:32]} : acc_next_s;
    assign post_in_s  = is_div_r ? {64'd0, (rem_sel_r ? acc_next_s[127:64] : acc_next_s[63:0])} : product_s;
    assign post_neg_s = (is_div_r && rem_sel_r) ? neg_rem_r : neg_prod_r;

    mdu_sign_fix #(.W(128)) u_post (.value(post_in_s), .negate(post_neg_s), .result(post_out_s));

    assign raw_s   = high_r ? post_out_s[127:64] : post_out_s[63:0];
    assign final_s = wop_r ? sext32(raw_s[31:0]) : raw_s;

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= MDU_IDLE;
            cnt_r      <= 7'd0;
            acc_r      <= 128'd0;
            mcand_r    <= 64'd0;
            res_r      <= 64'd0;
            rd_r       <= 5'd0;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            wop_r      <= 1'b0;
            is_div_r   <= 1'b0;
            rem_sel_r  <= 1'b0;
            high_r     <= 1'b0;
            neg_prod_r <= 1'b0;
            neg_rem_r  <= 1'b0;
        end else if (flush_i) begin
            state_r <= MDU_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                MDU_IDLE: begin
                    if (bus_s[MDU_VALID]) begin
                        wop_r      <= wop_s;
                        is_div_r   <= is_div_s;
                        rem_sel_r  <= bus_s[MDU_REM] | bus_s[MDU_REMU];
                        high_r     <= bus_s[MDU_MULH] | bus_s[MDU_MULHSU] | bus_s[MDU_MULHU];
                        neg_prod_r <= neg1_s ^ neg2_s;
                        neg_rem_r  <= neg1_s;
                        rd_r       <= mdu_rd_idx_i;
                        mcand_r    <= mag2_s;
                        acc_r      <= {64'd0, (is_div_s && wop_s) ? {mag1_s[31:0], 32'd0} : mag1_s};
                        cnt_r      <= wop_s ? 7'd32 : 7'd64;
                        ready_r    <= 1'b0;
                        busy_r     <= 1'b1;
                        if (div_zero_s || ovf_s) begin
                            state_r <= MDU_DONE;
                            res_r   <= special_res_s;
                            valid_r <= 1'b1;
                        end else begin
                            state_r <= MDU_CALC;
                        end
                    end else begin
                        state_r <= MDU_IDLE;
                    end
                end
                MDU_CALC: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r - 7'd1;
                    if (cnt_r == 7'd1) begin
                        state_r <= MDU_DONE;
                        res_r   <= final_s;
                        valid_r <= 1'b1;
                    end else begin
                        state_r <= MDU_CALC;
                    end
                end
                MDU_DONE: begin
                    if (mdu_res_ready_i) begin
                        state_r <= MDU_IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        valid_r <= 1'b0;
                    end else begin
                        state_r <= MDU_DONE;
                    end
                end
                default: begin
                    state_r <= MDU_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign mdu_ready_o     = ready_r;
    assign mdu_busy_o      = busy_r;
    assign mdu_res_valid_o = valid_r;
    assign mdu_res_o       = res_r;
    assign mdu_rd_idx_o    = rd_r;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: arithmetic reference model plus a per-cycle
// compare process, directed corner cases and randomized traffic.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, res_ready;
    logic [9:0]  bus;
    logic [63:0] op1, op2;
    logic [4:0]  rd_in;
    logic        ready, busy, valid;
    logic [63:0] res;
    logic [4:0]  rd_out;

    int total = 0;
    int bad = 0;
    bit checking = 0;

    bit          m_idle = 1;
    int          m_left = 0;
    logic [63:0] m_res = 64'd0;
    logic [4:0]  m_rd = 5'd0;
    logic        m_valid;

    always #5 clk = ~clk;

    mdu dut (
        .clk(clk), .rst(rst), .flush_i(flush), .mdu_info_bus_i(bus),
        .mdu_op1_i(op1), .mdu_op2_i(op2), .mdu_rd_idx_i(rd_in),
        .mdu_ready_o(ready), .mdu_busy_o(busy), .mdu_res_valid_o(valid),
        .mdu_res_o(res), .mdu_rd_idx_o(rd_out), .mdu_res_ready_i(res_ready)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] enc(input int op, input bit wop);
        logic [9:0] v;
        v = 10'd1;
        v[op] = 1'b1;
        v[MDU_WOP] = wop;
        return v;
    endfunction

    function automatic int op_of(input logic [9:0] b);
        for (int k = 2; k < 10; k++) if (b[k]) return k;
        return 2;
    endfunction

    function automatic bit is_special(input int op, input bit wop, input logic [63:0] a, input logic [63:0] b);
        bit zero, ovf;
        if (op < MDU_DIV) return 1'b0;
        if (wop) begin
            zero = (b[31:0] == 32'd0);
            ovf  = (op == MDU_DIV || op == MDU_REM) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
        end else begin
            zero = (b == 64'd0);
            ovf  = (op == MDU_DIV || op == MDU_REM) && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}};
        end
        return zero || ovf;
    endfunction

    // Reference result from plain arithmetic at the op's width.
    function automatic logic [63:0] ref_res(input int op, input bit wop, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, p;
        logic signed [63:0]  x, y;
        logic signed [31:0]  xs, ys;
        logic [31:0]         ua, ub, r;
        if (wop) begin
            ua = a[31:0]; ub = b[31:0]; xs = a[31:0]; ys = b[31:0];
            if (op == MDU_MUL) r = ua * ub;
            else if (op == MDU_DIV) begin
                if (ub == 32'd0) r = 32'hFFFF_FFFF;
                else if (is_special(op, wop, a, b)) r = ua;
                else r = xs / ys;
            end else if (op == MDU_DIVU) begin
                if (ub == 32'd0) r = 32'hFFFF_FFFF; else r = ua / ub;
            end else if (op == MDU_REM) begin
                if (ub == 32'd0) r = ua;
                else if (is_special(op, wop, a, b)) r = 32'd0;
                else r = xs % ys;
            end else begin
                if (ub == 32'd0) r = ua; else r = ua % ub;
            end
            return {{32{r[31]}}, r};
        end
        x = a; y = b;
        case (op)
            MDU_MUL:    begin sa = x; sb = y; p = sa * sb; return p[63:0]; end
            MDU_MULH:   begin sa = x; sb = y; p = sa * sb; return p[127:64]; end
            MDU_MULHSU: begin sa = x; sb = {64'd0, b}; p = sa * sb; return p[127:64]; end
            MDU_MULHU:  begin sa = {64'd0, a}; sb = {64'd0, b}; p = sa * sb; return p[127:64]; end
            MDU_DIV: begin
                if (b == 64'd0) return {64{1'b1}};
                if (is_special(op, wop, a, b)) return a;
                return x / y;
            end
            MDU_DIVU: begin
                if (b == 64'd0) return {64{1'b1}};
                return a / b;
            end
            MDU_REM: begin
                if (b == 64'd0) return a;
                if (is_special(op, wop, a, b)) return 64'd0;
                return x % y;
            end
            default: begin
                if (b == 64'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Model: result appears 65 cycles after accept (33 for word ops, 1 for special cases).
    always @(posedge clk) begin
        if (rst) begin
            m_idle = 1; m_left = 0; m_res = 64'd0; m_rd = 5'd0;
        end else if (flush) begin
            m_idle = 1;
        end else if (m_idle) begin
            if (bus[MDU_VALID]) begin
                m_idle = 0;
                m_res  = ref_res(op_of(bus), bus[MDU_WOP], op1, op2);
                m_rd   = rd_in;
                if (is_special(op_of(bus), bus[MDU_WOP], op1, op2)) m_left = 0;
                else if (bus[MDU_WOP]) m_left = 32;
                else m_left = 64;
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (res_ready) begin
            m_idle = 1;
        end
    end

    assign m_valid = !m_idle && (m_left == 0);

    always @(negedge clk) begin
        if (checking) begin
            chk("ready", {63'd0, ready}, {63'd0, m_idle});
            chk("busy", {63'd0, busy}, {63'd0, !m_idle});
            chk("valid", {63'd0, valid}, {63'd0, m_valid});
            if (m_valid) begin
                chk("res", res, m_res);
                chk("rd", {59'd0, rd_out}, {59'd0, m_rd});
            end
        end
    end

    // Issue one op, scramble inputs while busy, then handshake after 'hold' cycles.
    task automatic do_op(input int op, input bit wop, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input int hold, input int flush_at,
                         output int lat, output logic [63:0] seen);
        int n, waited;
        lat = 0; waited = 0; seen = 64'd0; n = 0;
        @(negedge clk);
        bus = enc(op, wop); op1 = a; op2 = b; rd_in = rd; flush = 1'b0; res_ready = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (m_idle) break;
            if (valid && lat == 0) begin lat = n; seen = res; end
            bus = 10'($urandom); op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom}; rd_in = 5'($urandom);
            flush = (n == flush_at);
            if (m_valid) begin res_ready = (waited >= hold); waited++; end
            else res_ready = 1'b0;
        end while (n < 300);
        if (!m_idle) chk("timeout", 64'd0, 64'd1);
        bus = 10'd0; flush = 1'b0; res_ready = 1'b0;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return {64{1'b1}};
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_8000_0000;
            4: return {32'd0, 32'($urandom_range(0, 20))};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int lat, op;
        bit w;
        logic [63:0] seen;
        rst = 1'b1; flush = 1'b0; res_ready = 1'b0; bus = 10'd0; op1 = 64'd0; op2 = 64'd0; rd_in = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_res", res, 64'd0);
        chk("rst_rd", {59'd0, rd_out}, 64'd0);
        rst = 1'b0;
        checking = 1;

        chk("ref_mul", ref_res(MDU_MUL, 0, {64{1'b1}}, 64'd7), 64'hFFFF_FFFF_FFFF_FFF9);
        chk("ref_mulhu", ref_res(MDU_MULHU, 0, {64{1'b1}}, {64{1'b1}}), 64'hFFFF_FFFF_FFFF_FFFE);
        chk("ref_mulhsu", ref_res(MDU_MULHSU, 0, {64{1'b1}}, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ref_divw", ref_res(MDU_DIV, 1, 64'h0000_0000_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("ref_remw", ref_res(MDU_REM, 1, 64'h0000_0000_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ref_remuw0", ref_res(MDU_REMU, 1, 64'd5, 64'd0), 64'd5);

        do_op(MDU_MUL, 0, {64{1'b1}}, 64'd7, 5'd3, 0, -1, lat, seen);
        chk("mul_lat", 64'(lat), 64'd65);
        chk("mul_res", seen, 64'hFFFF_FFFF_FFFF_FFF9);
        do_op(MDU_MULHU, 0, {64{1'b1}}, {64{1'b1}}, 5'd4, 0, -1, lat, seen);
        chk("mulhu_res", seen, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op(MDU_MULHSU, 0, {64{1'b1}}, 64'd2, 5'd5, 0, -1, lat, seen);
        chk("mulhsu_res", seen, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(MDU_DIV, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd6, 0, -1, lat, seen);
        chk("divw_lat", 64'(lat), 64'd33);
        chk("divw_res", seen, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(MDU_REM, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd7, 0, -1, lat, seen);
        chk("remw_res", seen, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(MDU_DIVU, 0, 64'd1234, 64'd0, 5'd8, 0, -1, lat, seen);
        chk("divu0_lat", 64'(lat), 64'd1);
        chk("divu0_res", seen, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(MDU_REM, 0, 64'h8000_0000_0000_0000, {64{1'b1}}, 5'd9, 0, -1, lat, seen);
        chk("removf_lat", 64'(lat), 64'd1);
        chk("removf_res", seen, 64'd0);
        do_op(MDU_REMU, 1, 64'd5, 64'd0, 5'd10, 0, -1, lat, seen);
        chk("remuw0_res", seen, 64'd5);
        do_op(MDU_DIV, 0, 64'd1000, 64'd7, 5'd11, 5, -1, lat, seen);
        chk("stall_res", seen, 64'd142);

        do_op(MDU_MUL, 0, 64'd3, 64'd4, 5'd12, 0, 10, lat, seen);
        chk("flush_nores", 64'(lat), 64'd0);
        @(negedge clk);
        bus = enc(MDU_MUL, 0); flush = 1'b1;
        @(negedge clk);
        bus = 10'd0; flush = 1'b0;
        chk("flush_idle_ready", {63'd0, ready}, 64'd1);
        @(negedge clk);
        chk("flush_noaccept", {63'd0, busy}, 64'd0);

        bus = enc(MDU_MUL, 0); op1 = 64'd9; op2 = 64'd9; rd_in = 5'd21;
        @(negedge clk);
        bus = 10'd0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstc_ready", {63'd0, ready}, 64'd1);
        chk("rstc_valid", {63'd0, valid}, 64'd0);
        chk("rstc_res", res, 64'd0);
        chk("rstc_rd", {59'd0, rd_out}, 64'd0);

        for (int i = 0; i < 250; i++) begin
            op = $urandom_range(2, 9);
            w = (op == MDU_MUL || op >= MDU_DIV) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_op(op, w, pick(), pick(), 5'($urandom), $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(1, 40) : -1, lat, seen);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
